// File: rtl/rvv_pkg.sv
// Shared vector-unit definitions: element-width codes, sequencer states and
// the chunking helpers used by both the sequencer and the ALU index math.
package rvv_pkg;

  typedef enum logic [2:0] {
    SEW8  = 3'd0,
    SEW16 = 3'd1,
    SEW32 = 3'd2,
    SEW64 = 3'd3
  } vsew_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Number of lane-wide chunks one element occupies (NCH).
  function automatic logic [4:0] nch_of(input logic [1:0] vsew, input int lane_width);
    int e;
    e = int'(vsew) + 3;
    if (e <= lane_width) return 5'd1;
    return 5'(1 << (e - lane_width));
  endfunction

  // Bits written per chunk: min(SEW, lane width).
  function automatic logic [7:0] chunk_bits(input logic [1:0] vsew, input int lane_width);
    int e;
    e = int'(vsew) + 3;
    if (e <= lane_width) return 8'(1 << e);
    return 8'(1 << lane_width);
  endfunction

endpackage

// File: rtl/rvv_acc_wr.sv
// VLEN-bit destination accumulator: parallel load of vd_old, or a masked
// write of one chunk at a variable bit position.
module rvv_acc_wr #(
  parameter int VLEN = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [VLEN-1:0] load_val,
  input  logic            wr_en,
  input  logic [9:0]      wr_idx,
  input  logic [63:0]     wr_data,
  input  logic [63:0]     wr_mask,
  output logic [VLEN-1:0] acc,
  output logic [VLEN-1:0] acc_next
);

  logic [VLEN-1:0] mask_sh;
  logic [VLEN-1:0] data_sh;

  // acc_next is exposed so the final chunk can reach vd_out on the same edge.
  always_comb begin
    mask_sh  = VLEN'(wr_mask) << wr_idx;
    data_sh  = VLEN'(wr_data & wr_mask) << wr_idx;
    acc_next = wr_en ? ((acc & ~mask_sh) | data_sh) : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/rvv_alu_seq.sv
// Sequencer walking one rvv_alu lane slice over vl elements, one chunk per
// cycle, assembling the destination register and reporting it with done.
module rvv_alu_seq
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int LANE_I     = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [9:0]      vl,
  input  logic [2:0]      vsew,
  input  logic [VLEN-1:0] vd_old,
  input  logic            stall,
  input  logic            alu_instr_valid,
  input  logic [63:0]     alu_vd,
  input  logic [9:0]      alu_index,
  output logic            alu_run,
  output logic [9:0]      alu_byte_i,
  output logic [3:0]      alu_in_reg_offset,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [VLEN-1:0] vd_out,
  output seq_state_e      state_dbg
);

  // Handshake: start is a one-cycle request honoured only in IDLE; busy is
  // high from the accepted start through the done cycle; done is a one-cycle
  // pulse with err qualified by it; vd_out holds until the next accepted start.

  seq_state_e      state;
  logic [9:0]      vl_q;
  logic [1:0]      vsew_q;
  logic [4:0]      nch_q;
  logic [7:0]      w_bits;
  logic [63:0]     wr_mask;
  logic [10:0]     vlmax;
  logic            illegal;
  logic            last_chunk;
  logic            last_elem;
  logic            tail_ok;
  logic            wr_en;
  logic            acc_load;
  logic [VLEN-1:0] acc;
  logic [VLEN-1:0] acc_next;

  assign nch_q      = nch_of(vsew_q, LANE_WIDTH);
  assign w_bits     = chunk_bits(vsew_q, LANE_WIDTH);
  assign wr_mask    = (w_bits == 8'd64) ? {64{1'b1}} : ((64'd1 << w_bits) - 64'd1);
  assign vlmax      = 11'(VLEN >> (int'(vsew[1:0]) + 3));
  assign illegal    = (vsew > SEW64) || ({1'b0, vl} > vlmax) || !alu_instr_valid;
  assign last_chunk = (alu_in_reg_offset == 4'(nch_q - 5'd1));
  assign last_elem  = (alu_byte_i == vl_q - 10'd1);
  // Global element index for this slice; elements at or beyond vl stay vd_old.
  assign tail_ok    = (32'(alu_byte_i) + 32'(LANE_I)) < 32'(vl_q);
  assign wr_en      = (state == ST_RUN) && tail_ok;
  assign acc_load   = (state == ST_IDLE) && start;
  assign state_dbg  = state;

  rvv_acc_wr #(
    .VLEN(VLEN)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .load     (acc_load),
    .load_val (vd_old),
    .wr_en    (wr_en),
    .wr_idx   (alu_index),
    .wr_data  (alu_vd),
    .wr_mask  (wr_mask),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      vl_q              <= '0;
      vsew_q            <= '0;
      alu_run           <= 1'b0;
      alu_byte_i        <= '0;
      alu_in_reg_offset <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      vd_out            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            vl_q              <= vl;
            vsew_q            <= vsew[1:0];
            alu_byte_i        <= '0;
            alu_in_reg_offset <= '0;
            busy              <= 1'b1;
            if (illegal) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              vd_out <= vd_old;
            end else if (vl == 10'd0) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              vd_out <= vd_old;
            end else begin
              state   <= ST_RUN;
              alu_run <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (last_chunk) begin
            alu_in_reg_offset <= '0;
            if (last_elem) begin
              state   <= ST_DONE;
              alu_run <= 1'b0;
              done    <= 1'b1;
              vd_out  <= acc_next;
            end else begin
              alu_byte_i <= alu_byte_i + 10'd1;
              // Stall only splits between elements: ALU carry state is per-clock.
              if (stall) begin
                state   <= ST_HOLD;
                alu_run <= 1'b0;
              end
            end
          end else begin
            alu_in_reg_offset <= alu_in_reg_offset + 4'd1;
          end
        end

        ST_HOLD: begin
          if (!stall) begin
            state   <= ST_RUN;
            alu_run <= 1'b1;
          end
        end

        ST_DONE: begin
          state             <= ST_IDLE;
          done              <= 1'b0;
          err               <= 1'b0;
          busy              <= 1'b0;
          alu_byte_i        <= '0;
          alu_in_reg_offset <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Bench for rvv_alu_seq: a behavioural vadd lane model answers the ALU side,
// expected results are queued at issue and checked when done appears.
module tb_rvv_alu_seq;
  import rvv_pkg::*;

  localparam int VLEN = 128;
  localparam int LW   = 3;
  localparam int CW   = VLEN + 1;
  typedef logic [CW-1:0] cw_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [9:0]      vl;
  logic [2:0]      vsew;
  logic [VLEN-1:0] vd_old;
  logic            stall;
  logic            alu_instr_valid;
  logic [63:0]     alu_vd;
  logic [9:0]      alu_index;
  logic            alu_run;
  logic [9:0]      alu_byte_i;
  logic [3:0]      alu_in_reg_offset;
  logic            busy;
  logic            done;
  logic            err;
  logic [VLEN-1:0] vd_out;
  seq_state_e      state_dbg;

  rvv_alu_seq #(.VLEN(VLEN), .LANE_WIDTH(LW), .LANE_I(0)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .vl                (vl),
    .vsew              (vsew),
    .vd_old            (vd_old),
    .stall             (stall),
    .alu_instr_valid   (alu_instr_valid),
    .alu_vd            (alu_vd),
    .alu_index         (alu_index),
    .alu_run           (alu_run),
    .alu_byte_i        (alu_byte_i),
    .alu_in_reg_offset (alu_in_reg_offset),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .vd_out            (vd_out),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboard ----------------
  int        n_tests = 0;
  int        n_fail  = 0;
  logic [VLEN:0] exp_q[$];
  int        lat_q[$];
  int        start_cyc = 0;

  task automatic chk(input string nm, input cw_t got, input cw_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural lane ALU (vadd) ----------------
  logic [VLEN-1:0] a_vec, b_vec;
  logic [2:0]      alu_sew_code;

  always_comb begin
    int sew, w;
    logic [VLEN-1:0] ta, tb;
    logic [63:0] m, s;
    sew = 8 << alu_sew_code[1:0];
    w   = (sew < (1 << LW)) ? sew : (1 << LW);
    m   = (sew == 64) ? {64{1'b1}} : ((64'd1 << sew) - 64'd1);
    ta  = a_vec >> (int'(alu_byte_i) * sew);
    tb  = b_vec >> (int'(alu_byte_i) * sew);
    s   = (ta[63:0] + tb[63:0]) & m;
    alu_vd    = s >> (int'(alu_in_reg_offset) * w);
    alu_index = 10'(int'(alu_byte_i) * sew + int'(alu_in_reg_offset) * w);
  end

  // Expected vd: element-wise sum for i < vl, old contents elsewhere.
  function automatic logic [VLEN-1:0] ref_vadd(input logic [VLEN-1:0] old, a, b,
                                               input int n_vl, input int n_vsew);
    logic [VLEN-1:0] r, ta, tb;
    logic [63:0] s;
    int sew;
    r   = old;
    sew = 8 << n_vsew;
    for (int i = 0; i < n_vl; i++) begin
      ta = a >> (i * sew);
      tb = b >> (i * sew);
      s  = ta[63:0] + tb[63:0];
      for (int k = 0; k < sew; k++) r[i * sew + k] = s[k];
    end
    return r;
  endfunction

  function automatic logic [VLEN-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  logic       prev_run  = 1'b0;
  logic [9:0] prev_byte = '0;
  logic [3:0] prev_off  = '0;

  always @(negedge clk) begin
    logic [VLEN:0] e;
    int l;
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", cw_t'(done), cw_t'(0));
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          chk("vd_out", cw_t'(vd_out), cw_t'(e[VLEN-1:0]));
          chk("err", cw_t'(err), cw_t'(e[VLEN]));
          if (l >= 0) chk("latency", cw_t'(cyc - start_cyc), cw_t'(l));
        end
      end
      if (alu_run) chk("busy_in_run", cw_t'(busy), cw_t'(1));
      // Chunks of one element must be issued back to back.
      if (alu_run && alu_in_reg_offset != 4'd0)
        chk("chunk_contig", cw_t'({prev_run, prev_byte, prev_off + 4'd1}),
            cw_t'({1'b1, alu_byte_i, alu_in_reg_offset}));
      prev_run  <= alu_run;
      prev_byte <= alu_byte_i;
      prev_off  <= alu_in_reg_offset;
    end else begin
      prev_run <= 1'b0;
    end
  end

  // ---------------- driver ----------------
  // st_mode: 0 no stall, 1 stall window [st_from, st_from+st_len) relative to
  // the start cycle with exp_holds known, 2 random stall (latency unchecked).
  task automatic run_op(input int n_vl, input int n_vsew, input logic [VLEN-1:0] old, a, b,
                        input logic iv, input int st_mode, input int st_from, input int st_len,
                        input int exp_holds, input logic poke);
    logic e_err;
    int nch, lat, rel;
    logic seen;
    e_err = (n_vsew > 3) || !iv || (n_vl > (VLEN / (8 << n_vsew)));
    nch   = (n_vsew + 3 <= LW) ? 1 : (1 << (n_vsew + 3 - LW));
    if (e_err || n_vl == 0) lat = 1;
    else if (st_mode == 2)  lat = -1;
    else                    lat = n_vl * nch + 1 + ((st_mode == 1) ? exp_holds : 0);
    exp_q.push_back({e_err, e_err ? old : ref_vadd(old, a, b, n_vl, n_vsew)});
    lat_q.push_back(lat);

    @(negedge clk);
    vl              = 10'(n_vl);
    vsew            = 3'(n_vsew);
    vd_old          = old;
    a_vec           = a;
    b_vec           = b;
    alu_sew_code    = 3'(n_vsew);
    alu_instr_valid = iv;
    start           = 1'b1;
    start_cyc       = cyc;
    seen            = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rel = cyc - start_cyc;
      if (done) begin
        seen  = 1'b1;
        start = poke;
        stall = 1'b0;
        break;
      end
      start = poke && ($urandom_range(0, 5) == 0);
      case (st_mode)
        1:       stall = (rel >= st_from) && (rel < st_from + st_len);
        2:       stall = ($urandom_range(0, 3) == 0);
        default: stall = 1'b0;
      endcase
    end
    if (!seen) begin
      chk("done_timeout", cw_t'(seen), cw_t'(1));
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    chk("idle_after_done", cw_t'({busy, done, alu_run}), cw_t'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [VLEN-1:0] a, b, ones;
    int vs, vmax, nvl;
    reset = 1'b1; start = 1'b0; stall = 1'b0; vl = '0; vsew = '0; vd_old = '0;
    alu_instr_valid = 1'b1; a_vec = '0; b_vec = '0; alu_sew_code = '0;
    ones = '1;
    repeat (3) @(negedge clk);
    chk("reset_state", cw_t'({alu_run, busy, done, err, alu_byte_i, alu_in_reg_offset}), cw_t'(0));
    chk("reset_vd_out", cw_t'(vd_out), cw_t'(0));
    reset = 1'b0;

    // vsew=0 vl=16: one chunk per element.
    run_op(16, 0, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 0, 0, 0, 0, 1'b0);
    // vsew=2 vl=4: 32-bit adds with carries rippling across byte chunks.
    a = {32'h7FFF_FFFF, 32'h00FF_FFFF, 32'h0000_FFFF, 32'h12FF_00FF};
    b = {32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0101_FF01};
    run_op(4, 2, rnd_vec(), a, b, 1'b1, 0, 0, 0, 0, 1'b0);
    // vl=2 with tail all ones.
    run_op(2, 0, ones, rnd_vec(), rnd_vec(), 1'b1, 0, 0, 0, 0, 1'b0);
    // vl=0, then rejected instructions; start poked in each done cycle.
    run_op(0, 1, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 0, 0, 0, 0, 1'b1);
    run_op(4, 4, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 0, 0, 0, 0, 1'b1);
    run_op(17, 0, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 0, 0, 0, 0, 1'b0);
    run_op(3, 1, rnd_vec(), rnd_vec(), rnd_vec(), 1'b0, 0, 0, 0, 0, 1'b0);
    // vsew=1 vl=4: stall high for cycles 4..6 (second chunk of element 1 onward).
    run_op(4, 1, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 1, 4, 3, 3, 1'b0);
    // 64-bit elements, 8 chunks each.
    run_op(2, 3, rnd_vec(), {64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF},
           {64'h0000_0000_0000_0002, 64'hFEDC_BA98_7654_3211}, 1'b1, 0, 0, 0, 0, 1'b1);

    // Reset in the middle of a run: nothing reported, then a clean restart.
    @(negedge clk);
    vl = 10'd16; vsew = 3'd0; vd_old = rnd_vec(); a_vec = rnd_vec(); b_vec = rnd_vec();
    alu_sew_code = 3'd0; alu_instr_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (alu_byte_i == 10'd5) break;
      @(negedge clk);
    end
    chk("reached_byte5", cw_t'(alu_byte_i), cw_t'(5));
    reset = 1'b1;
    #1;
    chk("midrun_reset", cw_t'({alu_run, busy, done, err, alu_byte_i, alu_in_reg_offset}), cw_t'(0));
    chk("midrun_reset_vd", cw_t'(vd_out), cw_t'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", cw_t'({busy, alu_run}), cw_t'(0));
    run_op(16, 0, rnd_vec(), rnd_vec(), rnd_vec(), 1'b1, 0, 0, 0, 0, 1'b0);

    // Randomized operations.
    for (int t = 0; t < 40; t++) begin
      vs   = $urandom_range(0, 3);
      vmax = VLEN / (8 << vs);
      nvl  = ($urandom_range(0, 9) == 0) ? vmax + 1 : $urandom_range(0, vmax);
      run_op(nvl, vs, rnd_vec(), rnd_vec(), rnd_vec(), ($urandom_range(0, 15) != 0),
             ($urandom_range(0, 1) == 1) ? 2 : 0, 0, 0, 0, ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", cw_t'(exp_q.size()), cw_t'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
